// File: rtl/spi_main_if.sv
// Request/response bus between the on-chip requester and spi_main.
interface spi_main_if #(
   parameter int OP_W   = 2,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) ();
   localparam int FRAME_W = OP_W + ADDR_W + DATA_W;

   logic               req_valid;
   logic               req_ready;
   logic [OP_W-1:0]    req_op;
   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_wdata;
   logic               rsp_valid;
   logic [DATA_W-1:0]  rsp_rdata;
   logic [FRAME_W-1:0] rsp_frame;
   logic               rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_frame, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_frame, rsp_err
   );
endinterface

// File: rtl/spi_main.sv
// SPI main for the 44-bit {op, addr, data} spi_sub frame: shifts a command out,
// waits a turnaround, shifts the echoed response back in and checks it.
module spi_main #(
   parameter int OP_W        = 2,
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 32,
   parameter int TURN_CYCLES = 1,
   parameter int GAP_CYCLES  = 2
) (
   input  logic     sclk,
   input  logic     rst,
   spi_main_if.slave bus,
   output logic     cs_n,
   output logic     mosi,
   input  logic     miso
);
   localparam int FRAME_W = OP_W + ADDR_W + DATA_W;
   localparam int HDR_W   = OP_W + ADDR_W;
   localparam logic [5:0] LAST_BIT  = 6'(FRAME_W - 1);
   localparam logic [5:0] TURN_LAST = 6'(TURN_CYCLES - 1);
   localparam logic [5:0] GAP_LAST  = 6'(GAP_CYCLES - 1);
   localparam logic [OP_W-1:0] OP_WRITE = OP_W'(1);

   typedef enum logic [2:0] {
      IDLE, TX, TURN, RX, DONE, ILLEGAL, GAP
   } state_t;

   state_t             state;
   logic [5:0]         bit_cnt;
   logic [FRAME_W-1:0] tx_frame;
   logic [FRAME_W-1:0] rx_shift;
   logic               ready;
   logic               rsp_valid;
   logic               rsp_err;
   logic [DATA_W-1:0]  rsp_rdata;
   logic [FRAME_W-1:0] rsp_frame;
   logic               hdr_bad;
   logic               data_bad;
   logic               is_write;

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_err   = rsp_err;
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_frame = rsp_frame;

   assign is_write = (tx_frame[FRAME_W-1 -: OP_W] == OP_WRITE);
   assign hdr_bad  = (rx_shift[FRAME_W-1 -: HDR_W] != tx_frame[FRAME_W-1 -: HDR_W]);
   assign data_bad = (rx_shift[DATA_W-1:0] != tx_frame[DATA_W-1:0]);

   // bit_cnt is shared by TX, TURN, RX and GAP; each phase restarts it at 0,
   // so it never runs past 43.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state     <= IDLE;
         cs_n      <= 1'b1;
         ready     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         rsp_frame <= '0;
         bit_cnt   <= '0;
         tx_frame  <= '0;
         rx_shift  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               ready <= 1'b1;
               if (bus.req_valid && ready) begin
                  ready    <= 1'b0;
                  tx_frame <= {bus.req_op, bus.req_addr, bus.req_wdata};
                  bit_cnt  <= '0;
                  if (bus.req_op[OP_W-1]) begin
                     state <= ILLEGAL;
                  end else begin
                     cs_n  <= 1'b0;
                     state <= TX;
                  end
               end
            end
            TX: begin
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= TURN;
               end else begin
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            TURN: begin
               if (bit_cnt == TURN_LAST) begin
                  bit_cnt <= '0;
                  state   <= RX;
               end else begin
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            RX: begin
               rx_shift <= {rx_shift[FRAME_W-2:0], miso};
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            DONE: begin
               cs_n      <= 1'b1;
               rsp_valid <= 1'b1;
               rsp_frame <= rx_shift;
               rsp_rdata <= rx_shift[DATA_W-1:0];
               rsp_err   <= hdr_bad || (is_write && data_bad);
               bit_cnt   <= '0;
               state     <= GAP;
            end
            ILLEGAL: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               bit_cnt   <= '0;
               state     <= GAP;
            end
            GAP: begin
               if (bit_cnt == GAP_LAST) begin
                  bit_cnt <= '0;
                  ready   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 6'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Launch on the falling edge so the sub sees a stable bit at the next rising edge.
   always_ff @(negedge sclk) begin
      if (rst || state != TX) begin
         mosi <= 1'b0;
      end else begin
         mosi <= tx_frame[LAST_BIT - bit_cnt];
      end
   end
endmodule

// File: tb/tb_spi_main.sv
// Directed bench: spi_main against a behavioural spi_sub with a 1024x32 memory.
module tb_spi_main;
   logic sclk = 1'b0;
   logic rst  = 1'b1;
   logic cs_n;
   logic mosi;
   logic miso = 1'b0;

   spi_main_if bus ();

   spi_main dut (
      .sclk (sclk),
      .rst  (rst),
      .bus  (bus.slave),
      .cs_n (cs_n),
      .mosi (mosi),
      .miso (miso)
   );

   always #5 sclk = ~sclk;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [1024];
   logic [43:0] sub_cmd  = '0;
   logic [43:0] sub_rsp  = '0;
   logic [43:0] last_cmd = '0;
   int sub_cnt  = 0;
   int rsp_idx  = 0;
   int flip_bit = -1;

   // Sub model: collect 44 command bits, access memory on the turnaround edge, then echo.
   always @(posedge sclk) begin
      if (cs_n) begin
         sub_cnt = 0;
         rsp_idx = 0;
      end else if (sub_cnt < 44) begin
         sub_cmd = {sub_cmd[42:0], mosi};
         sub_cnt++;
      end else if (sub_cnt == 44) begin
         last_cmd = sub_cmd;
         if (sub_cmd[43:42] == 2'b01) begin
            mem[sub_cmd[41:32]] = sub_cmd[31:0];
            sub_rsp = sub_cmd;
         end else begin
            sub_rsp = {sub_cmd[43:32], mem[sub_cmd[41:32]]};
         end
         if (flip_bit >= 0) sub_rsp[flip_bit] = ~sub_rsp[flip_bit];
         sub_cnt = 45;
      end
   end

   always @(negedge sclk) begin
      if (sub_cnt == 45 && rsp_idx < 44) begin
         miso = sub_rsp[43 - rsp_idx];
         rsp_idx++;
      end else begin
         miso = 1'b0;
      end
   end

   int cyc = 0, cs_low = 0, rsp_cnt = 0, acc_cnt = 0, acc_cyc = 0, rsp_cyc = 0;
   logic [43:0] cap_frame = '0;
   logic [31:0] cap_rdata = '0;
   logic        cap_err   = 1'b0;

   always @(posedge sclk) begin
      cyc++;
      if (!cs_n) cs_low++;
      if (bus.req_valid && bus.req_ready) begin
         acc_cnt++;
         acc_cyc = cyc;
      end
      if (bus.rsp_valid) begin
         rsp_cnt++;
         rsp_cyc   = cyc;
         cap_frame = bus.rsp_frame;
         cap_rdata = bus.rsp_rdata;
         cap_err   = bus.rsp_err;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] wdata);
      int n = 0;
      @(negedge sclk);
      while (!bus.req_ready && n < 200) begin
         @(negedge sclk);
         n++;
      end
      if (!bus.req_ready) begin
         checkOutput("ready_timeout", 64'd0, 64'd1);
      end else begin
         bus.req_valid = 1'b1;
         bus.req_op    = op;
         bus.req_addr  = addr;
         bus.req_wdata = wdata;
         @(posedge sclk);
         #1;
         bus.req_valid = 1'b0;
         bus.req_op    = 2'b00;
         bus.req_addr  = 10'h3FF;
         bus.req_wdata = 32'h5555AAAA;
      end
   endtask

   task automatic waitResponse(input int start_count);
      int n = 0;
      while (rsp_cnt == start_count && n < 300) begin
         @(negedge sclk);
         n++;
      end
      if (rsp_cnt == start_count) checkOutput("rsp_timeout", 64'd0, 64'd1);
      repeat (3) @(negedge sclk);
   endtask

   initial begin
      int r0, c0, a0, acc1, n;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h021] = 32'hFFFFFFFF;
      mem[10'h030] = 32'hA5A5A5A5;

      rst = 1'b1;
      repeat (3) @(posedge sclk);
      @(negedge sclk);
      #1;
      checkOutput("reset_cs_n", 64'(cs_n), 64'd1);
      checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
      checkOutput("reset_rsp_frame", 64'(bus.rsp_frame), 64'd0);
      checkOutput("reset_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("reset_mosi", 64'(mosi), 64'd0);
      rst = 1'b0;
      @(negedge sclk);
      checkOutput("ready_after_reset", 64'(bus.req_ready), 64'd1);

      // Write 0xDEADBEEF to 0x010 with full cycle accounting
      r0 = rsp_cnt; c0 = cs_low;
      applyStimulus(2'b01, 10'h010, 32'hDEADBEEF);
      waitResponse(r0);
      checkOutput("wr_err", 64'(cap_err), 64'd0);
      checkOutput("wr_frame", 64'(cap_frame), 64'({2'b01, 10'h010, 32'hDEADBEEF}));
      checkOutput("wr_mem", 64'(mem[10'h010]), 64'hDEADBEEF);
      checkOutput("wr_mosi_bits", 64'(last_cmd), 64'({2'b01, 10'h010, 32'hDEADBEEF}));
      checkOutput("wr_cs_low", 64'(cs_low - c0), 64'd90);
      checkOutput("wr_rsp_pulse", 64'(rsp_cnt - r0), 64'd1);
      checkOutput("wr_latency", 64'(rsp_cyc - acc_cyc), 64'd91);
      checkOutput("idle_mosi", 64'(mosi), 64'd0);

      // Read 0x010 back
      r0 = rsp_cnt;
      applyStimulus(2'b00, 10'h010, 32'h0);
      waitResponse(r0);
      checkOutput("rd_rdata", 64'(cap_rdata), 64'hDEADBEEF);
      checkOutput("rd_hdr", 64'(cap_frame[43:32]), 64'h010);
      checkOutput("rd_err", 64'(cap_err), 64'd0);

      // Back-to-back writes with req_valid held high throughout
      a0 = acc_cnt; c0 = cs_low; r0 = rsp_cnt; n = 0;
      @(negedge sclk);
      bus.req_valid = 1'b1;
      bus.req_op    = 2'b01;
      bus.req_addr  = 10'h020;
      bus.req_wdata = 32'h12345678;
      while (acc_cnt == a0 && n < 300) begin
         @(negedge sclk);
         n++;
      end
      acc1 = acc_cyc;
      bus.req_addr  = 10'h021;
      bus.req_wdata = 32'h00000000;
      n = 0;
      while (acc_cnt < a0 + 2 && n < 300) begin
         @(negedge sclk);
         n++;
      end
      bus.req_valid = 1'b0;
      checkOutput("b2b_accepts", 64'(acc_cnt - a0), 64'd2);
      checkOutput("b2b_spacing", 64'(acc_cyc - acc1), 64'd93);
      waitResponse(r0 + 1);
      checkOutput("b2b_mem0", 64'(mem[10'h020]), 64'h12345678);
      checkOutput("b2b_mem1", 64'(mem[10'h021]), 64'h0);
      checkOutput("b2b_cs_low", 64'(cs_low - c0), 64'd180);

      // Illegal opcode: immediate error response, no SPI activity
      r0 = rsp_cnt; c0 = cs_low;
      applyStimulus(2'b10, 10'h010, 32'h0BAD0BAD);
      waitResponse(r0);
      checkOutput("ill_latency", 64'(rsp_cyc - acc_cyc), 64'd2);
      checkOutput("ill_err", 64'(cap_err), 64'd1);
      checkOutput("ill_frame_held", 64'(cap_frame), 64'({2'b01, 10'h021, 32'h0}));
      checkOutput("ill_rdata_held", 64'(cap_rdata), 64'h0);
      checkOutput("ill_cs_low", 64'(cs_low - c0), 64'd0);
      checkOutput("ill_mem", 64'(mem[10'h010]), 64'hDEADBEEF);

      // Reset in the middle of a write to 0x030
      r0 = rsp_cnt;
      applyStimulus(2'b01, 10'h030, 32'h99999999);
      repeat (20) @(negedge sclk);
      rst = 1'b1;
      @(negedge sclk);
      checkOutput("midrst_cs_n", 64'(cs_n), 64'd1);
      @(negedge sclk);
      #1;
      checkOutput("midrst_mosi", 64'(mosi), 64'd0);
      rst = 1'b0;
      repeat (120) @(negedge sclk);
      checkOutput("midrst_no_rsp", 64'(rsp_cnt - r0), 64'd0);
      checkOutput("midrst_mem", 64'(mem[10'h030]), 64'hA5A5A5A5);

      r0 = rsp_cnt;
      applyStimulus(2'b01, 10'h030, 32'hCAFEF00D);
      waitResponse(r0);
      checkOutput("post_rst_wr_err", 64'(cap_err), 64'd0);
      r0 = rsp_cnt;
      applyStimulus(2'b00, 10'h030, 32'h0);
      waitResponse(r0);
      checkOutput("post_rst_rdata", 64'(cap_rdata), 64'hCAFEF00D);

      // Corrupted echo: data bit on a write, header bit on a read
      flip_bit = 5;
      r0 = rsp_cnt;
      applyStimulus(2'b01, 10'h040, 32'h11111111);
      waitResponse(r0);
      checkOutput("flip_wr_err", 64'(cap_err), 64'd1);
      flip_bit = 35;
      r0 = rsp_cnt;
      applyStimulus(2'b00, 10'h040, 32'h0);
      waitResponse(r0);
      checkOutput("flip_rd_err", 64'(cap_err), 64'd1);
      flip_bit = 5;
      r0 = rsp_cnt;
      applyStimulus(2'b00, 10'h040, 32'h0);
      waitResponse(r0);
      checkOutput("flip_rd_data_ok", 64'(cap_err), 64'd0);
      flip_bit = -1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
